// File: rtl/sync_cnt_checker.sv
// Upset monitor for a synchronized Gray-coded free-running counter: the decoded value
// must advance by 0 or +1 per local cycle; violations are flagged, counted and captured.
module sync_cnt_checker #(
    parameter int WIDTH   = 32,
    parameter int CNT_W   = 16,
    parameter int LOCK_N  = 8,
    parameter int MAX_BAD = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] gray_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [WIDTH-1:0] last_exp_o,
    output logic [WIDTH-1:0] last_got_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ACQ   = 2'b01,
        S_TRACK = 2'b10
    } state_t;

    localparam int LW = $clog2(LOCK_N + 1);
    localparam int BW = $clog2(MAX_BAD + 1);

    state_t           r_state;
    logic             r_locked;
    logic             r_err;
    logic             r_valid;
    logic [LW-1:0]    r_good;
    logic [BW-1:0]    r_bad;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_cur;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_exp;
    logic [WIDTH-1:0] r_got;

    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_delta;
    logic             w_good;

    // Each binary bit is the XOR of all Gray bits at and above it.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_g2b
            assign w_bin[gi] = ^gray_i[WIDTH-1:gi];
        end
    endgenerate

    assign w_delta = r_cur - r_prev;
    assign w_good  = (w_delta == '0) || (w_delta == WIDTH'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
            r_valid  <= 1'b0;
            r_good   <= '0;
            r_bad    <= '0;
            r_cnt    <= '0;
            r_cur    <= '0;
            r_prev   <= '0;
            r_exp    <= '0;
            r_got    <= '0;
        end else begin
            r_cur <= w_bin;
            r_err <= 1'b0;
            if (clr_i) begin
                r_cnt <= '0;
                r_exp <= '0;
                r_got <= '0;
            end
            if (!en_i) begin
                r_state  <= S_IDLE;
                r_locked <= 1'b0;
                r_valid  <= 1'b0;
                r_good   <= '0;
                r_bad    <= '0;
            end else begin
                r_prev <= r_cur;
                unique case (r_state)
                    S_IDLE: r_state <= S_ACQ;
                    S_ACQ: begin
                        if (!r_valid) begin
                            r_valid <= 1'b1;
                        end else if (w_good) begin
                            r_good <= r_good + LW'(1);
                            if (r_good == LW'(LOCK_N - 1)) begin
                                r_state  <= S_TRACK;
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_good <= '0;
                        end
                    end
                    S_TRACK: begin
                        if (w_good) begin
                            r_bad <= '0;
                        end else begin
                            r_err <= 1'b1;
                            // A coincident clear wins first, so this error becomes count 1.
                            if (clr_i)
                                r_cnt <= CNT_W'(1);
                            else if (r_cnt != {CNT_W{1'b1}})
                                r_cnt <= r_cnt + CNT_W'(1);
                            r_exp <= r_prev + WIDTH'(1);
                            r_got <= r_cur;
                            if (r_bad == BW'(MAX_BAD - 1)) begin
                                r_state  <= S_ACQ;
                                r_locked <= 1'b0;
                                r_good   <= '0;
                                r_bad    <= '0;
                            end else begin
                                r_bad <= r_bad + BW'(1);
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign locked_o   = r_locked;
    assign err_o      = r_err;
    assign err_cnt_o  = r_cnt;
    assign last_exp_o = r_exp;
    assign last_got_o = r_got;
    assign state_o    = r_state;

endmodule
